// File: rtl/interlock_pkg.sv
// Shared definitions for the bathysphere airlock: state codes shown on the
// HEX display and the direction constants used by the sequencer.
package interlock_pkg;

    // 4-bit state codes; IDLE and FAULT are pinned so the display is readable.
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FILL        = 4'd1,
        ST_OPEN_OUTER  = 4'd2,
        ST_CLOSE_OUTER = 4'd3,
        ST_EMPTY       = 4'd4,
        ST_OPEN_INNER  = 4'd5,
        ST_CLOSE_INNER = 4'd6,
        ST_FAULT       = 4'd15
    } state_e;

    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

endpackage

// File: rtl/wait_timer.sv
// Saturating cycle counter with synchronous clear. done is high while the
// count has reached the terminal count, so a caller passing N-1 sees done
// in the N-th enabled cycle after a clear.
module wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal_count,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = enable && (count_q >= terminal_count);

endmodule

// File: rtl/interlock_sequencer.sv
// Airlock sequencer: walks the chamber through fill/empty and gate
// open/close steps to move the bathysphere between sea and station.
// Every output is a flop loaded from the next state, so outputs always
// match the state the block is in during that cycle.
module interlock_sequencer
    import interlock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       chamber_full,
    input  logic       bath_in_chamber,
    output logic       fill_cmd,
    output logic       empty_cmd,
    output logic       outer_open,
    output logic       inner_open,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC  = CNT_W'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic       dir_q, dir_d;

    logic       fill_cmd_q, fill_cmd_d;
    logic       empty_cmd_q, empty_cmd_d;
    logic       outer_open_q, outer_open_d;
    logic       inner_open_q, inner_open_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fault_q, fault_d;
    logic [3:0] state_code_q, state_code_d;

    logic             timer_clear;
    logic             timer_enable;
    logic [CNT_W-1:0] timer_tc;
    logic             timer_done;

    // Closing states time the settle period; waiting states time the response limit.
    always_comb begin
        timer_clear  = (state_d != state_q);
        timer_enable = (state_q != ST_IDLE) && (state_q != ST_FAULT);
        timer_tc     = ((state_q == ST_CLOSE_OUTER) || (state_q == ST_CLOSE_INNER))
                       ? SETTLE_TC : TIMEOUT_TC;
    end

    wait_timer #(
        .WIDTH (CNT_W)
    ) u_wait_timer (
        .clk            (clk),
        .reset          (reset),
        .clear          (timer_clear),
        .enable         (timer_enable),
        .terminal_count (timer_tc),
        .done           (timer_done)
    );

    // State, direction and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_ARRIVE;
            fill_cmd_q   <= 1'b0;
            empty_cmd_q  <= 1'b0;
            outer_open_q <= 1'b0;
            inner_open_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            state_code_q <= ST_IDLE;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            fill_cmd_q   <= fill_cmd_d;
            empty_cmd_q  <= empty_cmd_d;
            outer_open_q <= outer_open_d;
            inner_open_q <= inner_open_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            state_code_q <= state_code_d;
        end
    end

    // Next state: a gate-open state faults if the water level moves under it.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (arrive_req) begin
                    dir_d   = DIR_ARRIVE;
                    state_d = chamber_full ? ST_OPEN_OUTER : ST_FILL;
                end else if (depart_req) begin
                    dir_d   = DIR_DEPART;
                    state_d = chamber_full ? ST_EMPTY : ST_OPEN_INNER;
                end
            end
            ST_FILL: begin
                if (chamber_full)    state_d = ST_OPEN_OUTER;
                else if (timer_done) state_d = ST_FAULT;
            end
            ST_EMPTY: begin
                if (!chamber_full)   state_d = ST_OPEN_INNER;
                else if (timer_done) state_d = ST_FAULT;
            end
            ST_OPEN_OUTER: begin
                if (!chamber_full)                                     state_d = ST_FAULT;
                else if (bath_in_chamber == (dir_q == DIR_ARRIVE))     state_d = ST_CLOSE_OUTER;
                else if (timer_done)                                   state_d = ST_FAULT;
            end
            ST_OPEN_INNER: begin
                if (chamber_full)                                      state_d = ST_FAULT;
                else if (bath_in_chamber == (dir_q == DIR_DEPART))     state_d = ST_CLOSE_INNER;
                else if (timer_done)                                   state_d = ST_FAULT;
            end
            ST_CLOSE_OUTER: begin
                if (timer_done) state_d = (dir_q == DIR_ARRIVE) ? ST_EMPTY : ST_IDLE;
            end
            ST_CLOSE_INNER: begin
                if (timer_done) state_d = (dir_q == DIR_ARRIVE) ? ST_IDLE : ST_FILL;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        fill_cmd_d   = (state_d == ST_FILL)  && (state_q != ST_FILL);
        empty_cmd_d  = (state_d == ST_EMPTY) && (state_q != ST_EMPTY);
        outer_open_d = (state_d == ST_OPEN_OUTER);
        inner_open_d = (state_d == ST_OPEN_INNER);
        busy_d       = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        done_d       = ((state_q == ST_CLOSE_OUTER) || (state_q == ST_CLOSE_INNER))
                       && (state_d == ST_IDLE);
        fault_d      = (state_d == ST_FAULT);
        state_code_d = state_d;
    end

    assign fill_cmd   = fill_cmd_q;
    assign empty_cmd  = empty_cmd_q;
    assign outer_open = outer_open_q;
    assign inner_open = inner_open_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign state_code = state_code_q;

endmodule

// File: tb/tb_interlock_sequencer.sv
// Randomized bench for interlock_sequencer. Each transaction is described by
// direction, starting water level and response delays; the expected outcome
// is computed as a list of step durations and compared with what the bench
// observes on the outputs.
module tb_interlock_sequencer;

    localparam int T     = 200;
    localparam int S     = 4;
    localparam int LIMIT = 6 * (T + 1) + 2 * S + 20;

    localparam int K_FILL  = 0;
    localparam int K_EMPTY = 1;
    localparam int K_OUTER = 2;
    localparam int K_INNER = 3;
    localparam int K_CLOSE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arrive_req = 1'b0;
    logic       depart_req = 1'b0;
    logic       chamber_full = 1'b0;
    logic       bath_in_chamber = 1'b0;
    logic       fill_cmd, empty_cmd, outer_open, inner_open;
    logic       busy, done, fault;
    logic [3:0] state_code;

    int tests  = 0;
    int errors = 0;

    interlock_sequencer #(
        .TIMEOUT_CYCLES (T),
        .SETTLE_CYCLES  (S)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .arrive_req      (arrive_req),
        .depart_req      (depart_req),
        .chamber_full    (chamber_full),
        .bath_in_chamber (bath_in_chamber),
        .fill_cmd        (fill_cmd),
        .empty_cmd       (empty_cmd),
        .outer_open      (outer_open),
        .inner_open      (inner_open),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .state_code      (state_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        arrive_req = 1'b0;
        depart_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_seq(input int id, input bit d, input bit init_full,
                           input int df, input int de, input int db1, input int db2,
                           input bit both, input bit flood);
        int kind[6];
        int dly[6];
        int n, dur;
        int exp_busy, exp_fill, exp_empty, exp_outer, exp_inner, exp_lat;
        bit exp_fault, exp_first_outer;
        int obs_busy, obs_fill, obs_empty, obs_outer, obs_inner, obs_overlap, obs_lat, obs_done;
        bit obs_first_outer, prev_outer, prev_inner, ended, done_at_end;
        int fill_at, empty_at, bath_at, opens, bad;

        // Expected step list for the requested direction.
        n = 0;
        if (!d) begin
            if (!init_full) begin kind[n] = K_FILL; dly[n] = df; n++; end
            kind[n] = K_OUTER; dly[n] = db1; n++;
            kind[n] = K_CLOSE; dly[n] = 0;   n++;
            kind[n] = K_EMPTY; dly[n] = de;  n++;
            kind[n] = K_INNER; dly[n] = db2; n++;
            kind[n] = K_CLOSE; dly[n] = 0;   n++;
        end else begin
            if (init_full) begin kind[n] = K_EMPTY; dly[n] = de; n++; end
            kind[n] = K_INNER; dly[n] = db1; n++;
            kind[n] = K_CLOSE; dly[n] = 0;   n++;
            kind[n] = K_FILL;  dly[n] = df;  n++;
            kind[n] = K_OUTER; dly[n] = db2; n++;
            kind[n] = K_CLOSE; dly[n] = 0;   n++;
        end

        exp_busy = 0; exp_fill = 0; exp_empty = 0; exp_outer = 0; exp_inner = 0;
        exp_lat = -1; exp_fault = 0; exp_first_outer = 0;
        for (int i = 0; i < n; i++) begin
            if (!exp_fault) begin
                if (kind[i] == K_CLOSE)  dur = S;
                else if (dly[i] >= T)    begin dur = T; exp_fault = 1; end
                else                     dur = dly[i] + 1;
                if ((kind[i] == K_OUTER || kind[i] == K_INNER) && exp_lat < 0) begin
                    exp_lat         = exp_busy + 1;
                    exp_first_outer = (kind[i] == K_OUTER);
                end
                if (kind[i] == K_FILL)  exp_fill++;
                if (kind[i] == K_EMPTY) exp_empty++;
                if (kind[i] == K_OUTER) exp_outer += dur;
                if (kind[i] == K_INNER) exp_inner += dur;
                exp_busy += dur;
            end
        end

        // Drive the request and play the pressure controller / sensor.
        @(negedge clk);
        chamber_full    = init_full;
        bath_in_chamber = 1'b0;
        arrive_req      = !d || both;
        depart_req      = d || both;
        obs_busy = 0; obs_fill = 0; obs_empty = 0; obs_outer = 0; obs_inner = 0;
        obs_overlap = 0; obs_lat = -1; obs_done = 0; obs_first_outer = 0;
        prev_outer = 0; prev_inner = 0; ended = 0; done_at_end = 0;
        fill_at = -1; empty_at = -1; bath_at = -1; opens = 0;

        for (int c = 1; c <= LIMIT && !ended; c++) begin
            @(negedge clk);
            if (busy) obs_busy++;
            if (fill_cmd)  begin obs_fill++;  fill_at  = c + df; end
            if (empty_cmd) begin obs_empty++; empty_at = c + de; end
            if (outer_open) obs_outer++;
            if (inner_open) obs_inner++;
            if (outer_open && inner_open) obs_overlap++;
            if ((outer_open && !prev_outer) || (inner_open && !prev_inner)) begin
                if (obs_lat < 0) begin obs_lat = c; obs_first_outer = outer_open; end
                bath_at = c + ((opens == 0) ? db1 : db2);
                opens++;
            end
            if (done) obs_done++;
            prev_outer = outer_open;
            prev_inner = inner_open;
            if (!busy) begin ended = 1; done_at_end = done; end
            if (c == fill_at)  chamber_full = 1'b1;
            if (c == empty_at) chamber_full = 1'b0;
            if (c == bath_at)  bath_in_chamber = !bath_in_chamber;
            arrive_req = flood && busy && ($urandom_range(0, 1) == 1);
            depart_req = flood && busy && ($urandom_range(0, 1) == 1);
        end
        arrive_req = 1'b0;
        depart_req = 1'b0;

        $display("[TB] seq %0d dir=%0d full0=%0d busy_cycles=%0d/%0d fault=%0d/%0d",
                 id, d, init_full, obs_busy, exp_busy, fault, exp_fault);
        check("seq_ended",     32'(ended), 1);
        check("busy_cycles",   obs_busy, exp_busy);
        check("fill_pulses",   obs_fill, exp_fill);
        check("empty_pulses",  obs_empty, exp_empty);
        check("outer_cycles",  obs_outer, exp_outer);
        check("inner_cycles",  obs_inner, exp_inner);
        check("gate_overlap",  obs_overlap, 0);
        check("first_open_lat", obs_lat, exp_lat);
        check("first_gate_outer", 32'(obs_first_outer), 32'(exp_first_outer));
        check("done_pulse",    32'(done_at_end), 32'(!exp_fault));
        check("done_count",    obs_done, exp_fault ? 0 : 1);
        check("fault_flag",    32'(fault), 32'(exp_fault));
        check("end_state_code", 32'(state_code), exp_fault ? 15 : 0);

        if (exp_fault || fault) begin
            bad = 0;
            repeat (5) begin
                @(negedge clk);
                if (!(fault && !outer_open && !inner_open && !fill_cmd && !empty_cmd
                      && !busy && state_code == 4'd15)) bad++;
            end
            check("fault_hold", bad, 0);
            do_reset();
            check("post_reset_fault", 32'(fault), 0);
        end else begin
            @(negedge clk);
            check("done_one_cycle", 32'(done), 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd, rf, rb;
        int rdf, rde, rdb1, rdb2, pick;

        // Reset state.
        do_reset();
        $display("[TB] reset check");
        check("rst_busy",  32'(busy), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_gates", 32'({outer_open, inner_open}), 0);
        check("rst_cmds",  32'({fill_cmd, empty_cmd, done}), 0);
        check("rst_state", 32'(state_code), 0);

        // Arrival from empty chamber.
        run_seq(0, 1'b0, 1'b0, 10, 3, 5, 5, 1'b0, 1'b0);
        // Departure with chamber already empty: inner gate opens next cycle.
        run_seq(1, 1'b1, 1'b0, 6, 0, 3, 4, 1'b0, 1'b0);
        // Simultaneous requests: arrival wins; requests while busy ignored.
        run_seq(2, 1'b0, 1'b0, 4, 2, 3, 3, 1'b1, 1'b1);
        // Fill response just inside the limit, then just outside it.
        run_seq(3, 1'b0, 1'b0, T - 1, 1, 1, 1, 1'b0, 1'b0);
        run_seq(4, 1'b0, 1'b0, T, 1, 1, 1, 1'b0, 1'b0);
        // Bathysphere never arrives at the inner gate.
        run_seq(5, 1'b1, 1'b1, 2, 2, T + 5, 2, 1'b0, 1'b0);

        // Water level drops while the outer gate is open.
        @(negedge clk);
        chamber_full = 1'b1; bath_in_chamber = 1'b0; arrive_req = 1'b1;
        @(negedge clk);
        arrive_req = 1'b0;
        $display("[TB] level drop during outer open");
        check("drop_pre_open", 32'(outer_open), 1);
        @(negedge clk);
        chamber_full = 1'b0;
        @(negedge clk);
        check("drop_fault", 32'(fault), 1);
        check("drop_outer", 32'(outer_open), 0);
        check("drop_state", 32'(state_code), 15);
        do_reset();

        // Reset while the inner gate is open.
        @(negedge clk);
        chamber_full = 1'b0; bath_in_chamber = 1'b0; depart_req = 1'b1;
        @(negedge clk);
        depart_req = 1'b0;
        $display("[TB] reset during inner open");
        check("rst_pre_open", 32'(inner_open), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_inner", 32'(inner_open), 0);
        check("midrst_busy",  32'(busy), 0);
        check("midrst_state", 32'(state_code), 0);
        reset = 1'b0;

        // Random transactions.
        for (int k = 0; k < 40; k++) begin
            rd   = ($urandom_range(0, 1) == 1);
            rf   = ($urandom_range(0, 1) == 1);
            rb   = !rd && ($urandom_range(0, 3) == 0);
            rdf  = $urandom_range(0, 12);
            rde  = $urandom_range(0, 12);
            rdb1 = $urandom_range(0, 12);
            rdb2 = $urandom_range(0, 12);
            if ($urandom_range(0, 9) == 0) begin
                pick = $urandom_range(0, 3);
                if (pick == 0) rdf  = $urandom_range(T, T + 10);
                if (pick == 1) rde  = $urandom_range(T, T + 10);
                if (pick == 2) rdb1 = $urandom_range(T, T + 10);
                if (pick == 3) rdb2 = $urandom_range(T, T + 10);
            end
            run_seq(10 + k, rd, rf, rdf, rde, rdb1, rdb2, rb, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
